// File: rtl/cordic_nco_feed_if.sv
// cordic_nco_feed_if: configuration handshake between a controller and the NCO feed
interface cordic_nco_feed_if #(
  parameter int WIDTH = 16,
  parameter int PHASE_WIDTH = 32
);
  logic cfg_valid;
  logic cfg_ready;
  logic [PHASE_WIDTH-1:0] cfg_freq;
  logic [PHASE_WIDTH-1:0] cfg_phase;
  logic [WIDTH-2:0] cfg_amp;
  modport master (output cfg_valid, cfg_freq, cfg_phase, cfg_amp, input cfg_ready);
  modport slave (input cfg_valid, cfg_freq, cfg_phase, cfg_amp, output cfg_ready);
endinterface

// File: rtl/cordic_nco_feed.sv
// cordic_nco_feed: phase accumulator and amplitude pre-scaler driving a rotating-mode CORDIC, with aligned valid/wrap
module cordic_nco_feed #(
  parameter int WIDTH = 16,
  parameter int PHASE_WIDTH = 32,
  parameter int ITERATIONS = WIDTH + 2,
  parameter int CORDIC_LATENCY = ITERATIONS + 2,
  parameter int INV_K = 39797
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_i,
  cordic_nco_feed_if.slave cfg,
  output logic [WIDTH-1:0] x0_o,
  output logic [WIDTH-1:0] y0_o,
  output logic [WIDTH-1:0] z0_o,
  output logic in_valid_o,
  output logic out_valid_o,
  output logic out_wrap_o
);
  localparam int PROD_W = WIDTH + 16;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state_q;
  logic [PHASE_WIDTH-1:0] acc_q, freq_q, phase_q;
  logic [WIDTH-2:0] amp_q;
  logic [WIDTH-1:0] x0_q, z0_q;
  logic in_valid_q, in_wrap_q;
  logic [CORDIC_LATENCY-1:0] dv_q, dw_q;
  logic accept;
  logic [PHASE_WIDTH:0] acc_sum;
  logic [PROD_W-1:0] prod_d;
  assign accept = cfg.cfg_valid & cfg.cfg_ready;
  assign acc_sum = {1'b0, acc_q} + {1'b0, freq_q};
  // amp * (1/K) in Q0.16, rounded to nearest; the top bit stays clear so x0 is a non-negative signed value
  assign prod_d = PROD_W'(amp_q) * PROD_W'(INV_K) + (PROD_W'(1) << 15);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q <= '0;
      freq_q <= '0;
      phase_q <= '0;
      amp_q <= '0;
      x0_q <= '0;
      z0_q <= '0;
      in_valid_q <= 1'b0;
      in_wrap_q <= 1'b0;
      dv_q <= '0;
      dw_q <= '0;
    end else begin
      dv_q <= {dv_q[CORDIC_LATENCY-2:0], in_valid_q};
      dw_q <= {dw_q[CORDIC_LATENCY-2:0], in_wrap_q};
      in_valid_q <= state_q == RUN;
      in_wrap_q <= state_q == RUN && acc_sum[PHASE_WIDTH];
      if (accept) begin
        freq_q <= cfg.cfg_freq;
        phase_q <= cfg.cfg_phase;
        amp_q <= cfg.cfg_amp;
      end
      case (state_q)
        IDLE: state_q <= accept ? LOAD : enable_i ? RUN : IDLE;
        LOAD: begin
          acc_q <= phase_q;
          x0_q <= prod_d[PROD_W-1 -: WIDTH];
          state_q <= enable_i ? RUN : IDLE;
        end
        RUN: begin
          z0_q <= acc_q[PHASE_WIDTH-1 -: WIDTH];
          acc_q <= acc_sum[PHASE_WIDTH-1:0];
          state_q <= accept ? LOAD : enable_i ? RUN : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign cfg.cfg_ready = state_q != LOAD;
  assign x0_o = x0_q;
  assign y0_o = '0;
  assign z0_o = z0_q;
  assign in_valid_o = in_valid_q;
  assign out_valid_o = dv_q[CORDIC_LATENCY-1];
  assign out_wrap_o = dw_q[CORDIC_LATENCY-1];
endmodule

// File: tb/tb_cordic_nco_feed.sv
// tb_cordic_nco_feed: scenario tasks plus randomized run against a sample-level oscillator model
module tb_cordic_nco_feed;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [15:0] x0, y0, z0;
  logic in_valid, out_valid, out_wrap;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  cordic_nco_feed_if #(.WIDTH(16), .PHASE_WIDTH(32)) cfg ();
  cordic_nco_feed dut (
    .clk(clk), .reset(reset), .enable_i(enable), .cfg(cfg),
    .x0_o(x0), .y0_o(y0), .z0_o(z0),
    .in_valid_o(in_valid), .out_valid_o(out_valid), .out_wrap_o(out_wrap)
  );
  // model: oscillator mode, phase, latched config, produced sample and its wrap
  logic [31:0] m_acc, m_freq, m_phase;
  logic [14:0] m_amp;
  logic [15:0] m_x0, m_z0;
  bit m_load, m_run, m_iv, m_wr;
  bit hist_iv [4096];
  bit hist_wr [4096];
  int cyc = 0;
  int rst_cyc = 0;
  function automatic bit exp_ov();
    return (cyc - 20 >= rst_cyc) ? hist_iv[(cyc - 20) % 4096] : 1'b0;
  endfunction
  function automatic bit exp_ow();
    return (cyc - 20 >= rst_cyc) ? hist_wr[(cyc - 20) % 4096] : 1'b0;
  endfunction
  task automatic cycle(input bit en, input bit cv, input logic [31:0] f, input logic [31:0] p, input logic [14:0] a);
    bit acc;
    longint s;
    enable = en;
    cfg.cfg_valid = cv;
    cfg.cfg_freq = f;
    cfg.cfg_phase = p;
    cfg.cfg_amp = a;
    acc = cv && !m_load;
    if (m_load) begin
      m_acc = m_phase;
      m_x0 = 16'((int'(m_amp) * 39797 + 32768) / 65536);
      m_iv = 0;
      m_wr = 0;
      m_load = 0;
      m_run = en;
    end else begin
      if (m_run) begin
        m_z0 = m_acc[31:16];
        s = longint'(m_acc) + longint'(m_freq);
        m_wr = s >= 64'h1_0000_0000;
        m_acc = 32'(s);
        m_iv = 1;
      end else begin
        m_iv = 0;
        m_wr = 0;
      end
      m_run = !acc && en;
      m_load = acc;
      if (acc) begin
        m_freq = f;
        m_phase = p;
        m_amp = a;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    hist_iv[cyc % 4096] = m_iv;
    hist_wr[cyc % 4096] = m_wr;
  endtask
  task automatic assert_reset();
    reset = 1'b1;
    #1;
    m_acc = 0; m_freq = 0; m_phase = 0; m_amp = 0; m_x0 = 0; m_z0 = 0;
    m_load = 0; m_run = 0; m_iv = 0; m_wr = 0;
  endtask
  task automatic release_reset();
    enable = 1'b0;
    cfg.cfg_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rst_cyc = cyc;
    hist_iv[cyc % 4096] = 0;
    hist_wr[cyc % 4096] = 0;
  endtask
  task automatic test_reset();
    assert_reset();
    checks++; if ({x0, y0, z0} !== 48'h0) $display("FAIL reset_data: got %h want 0", {x0, y0, z0});
    checks++; if ({in_valid, out_valid, out_wrap} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {in_valid, out_valid, out_wrap});
    release_reset();
    checks++; if (cfg.cfg_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cfg.cfg_ready);
    if ({x0, y0, z0} !== 48'h0) errors++;
    if ({in_valid, out_valid, out_wrap} !== 3'b000) errors++;
    if (cfg.cfg_ready !== 1'b1) errors++;
  endtask
  task automatic test_quadrants();
    logic [15:0] exp_z [5] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h0000};
    cycle(1, 1, 32'h4000_0000, 32'h0, 15'h7FFF);
    checks++; if (cfg.cfg_ready !== 1'b0) begin errors++; $display("FAIL quad_ready_load: got %b want 0", cfg.cfg_ready); end
    cycle(1, 0, 32'h0, 32'h0, 15'h0);
    checks++; if (x0 !== 16'd19898) begin errors++; $display("FAIL quad_x0: got %0d want 19898", x0); end
    checks++; if (in_valid !== 1'b0) begin errors++; $display("FAIL quad_bubble: got %b want 0", in_valid); end
    for (int k = 0; k < 25; k++) begin
      cycle(1, 0, 32'h0, 32'h0, 15'h0);
      if (k < 5) begin
        checks++; if (z0 !== exp_z[k]) begin errors++; $display("FAIL quad_z0[%0d]: got %h want %h", k, z0, exp_z[k]); end
        checks++; if (in_valid !== 1'b1) begin errors++; $display("FAIL quad_in_valid[%0d]: got %b want 1", k, in_valid); end
      end
      checks++; if (out_valid !== (k >= 20)) begin errors++; $display("FAIL quad_out_valid[%0d]: got %b want %b", k, out_valid, k >= 20); end
      checks++; if (out_wrap !== (k == 23)) begin errors++; $display("FAIL quad_out_wrap[%0d]: got %b want %b", k, out_wrap, k == 23); end
    end
  endtask
  task automatic test_enable_gap();
    int iv_low = 0;
    int ov_low = 0;
    logic [15:0] z_before = 16'h0;
    for (int k = 0; k < 35; k++) begin
      cycle(!(k >= 2 && k < 5), 0, 32'h0, 32'h0, 15'h0);
      if (k == 2) z_before = m_z0;
      if (!in_valid) iv_low++;
      if (!out_valid) ov_low++;
      checks++; if (in_valid !== m_iv) begin errors++; $display("FAIL gap_in_valid[%0d]: got %b want %b", k, in_valid, m_iv); end
      checks++; if (z0 !== m_z0) begin errors++; $display("FAIL gap_z0[%0d]: got %h want %h", k, z0, m_z0); end
      checks++; if (out_valid !== exp_ov()) begin errors++; $display("FAIL gap_out_valid[%0d]: got %b want %b", k, out_valid, exp_ov()); end
      if (k == 6) begin
        checks++; if (z0 !== z_before + 16'h4000) begin errors++; $display("FAIL gap_resume: got %h want %h", z0, z_before + 16'h4000); end
      end
    end
    checks++; if (iv_low != 3) begin errors++; $display("FAIL gap_in_low_count: got %0d want 3", iv_low); end
    checks++; if (ov_low != 3) begin errors++; $display("FAIL gap_out_low_count: got %0d want 3", ov_low); end
  endtask
  task automatic test_reconfig();
    cycle(1, 1, 32'h1, 32'h8000_0000, 15'h0);
    checks++; if (cfg.cfg_ready !== 1'b0) begin errors++; $display("FAIL recfg_ready: got %b want 0", cfg.cfg_ready); end
    checks++; if (in_valid !== 1'b1) begin errors++; $display("FAIL recfg_last_sample: got %b want 1", in_valid); end
    cycle(1, 0, 32'h0, 32'h0, 15'h0);
    checks++; if (cfg.cfg_ready !== 1'b1) begin errors++; $display("FAIL recfg_ready_back: got %b want 1", cfg.cfg_ready); end
    checks++; if (in_valid !== 1'b0) begin errors++; $display("FAIL recfg_bubble: got %b want 0", in_valid); end
    checks++; if (x0 !== 16'h0) begin errors++; $display("FAIL recfg_x0: got %h want 0", x0); end
    for (int k = 0; k < 2; k++) begin
      cycle(1, 0, 32'h0, 32'h0, 15'h0);
      checks++; if (z0 !== 16'h8000 || in_valid !== 1'b1) begin errors++; $display("FAIL recfg_z0[%0d]: got %h/%b want 8000/1", k, z0, in_valid); end
    end
  endtask
  task automatic test_decrement(input logic [31:0] p);
    logic [31:0] a;
    cycle(1, 1, 32'hFFFF_FFFF, p, 15'($urandom()));
    cycle(1, 0, 32'h0, 32'h0, 15'h0);
    for (int k = 0; k < 26; k++) begin
      cycle(1, 0, 32'h0, 32'h0, 15'h0);
      a = p - 32'(k);
      if (k < 6) begin
        checks++; if (z0 !== a[31:16]) begin errors++; $display("FAIL dec_z0[%0d]: got %h want %h", k, z0, a[31:16]); end
      end
      if (k >= 20) begin
        a = p - 32'(k - 20);
        checks++; if (out_wrap !== (a != 0) || out_valid !== 1'b1) begin
          errors++; $display("FAIL dec_wrap[%0d]: got %b/%b want %b/1", k - 20, out_wrap, out_valid, a != 0);
        end
      end
    end
  endtask
  task automatic test_hold_valid_idle();
    for (int k = 0; k < 3; k++) cycle(0, 0, 32'h0, 32'h0, 15'h0);
    for (int k = 0; k < 10; k++) begin
      cycle(0, 1, $urandom(), $urandom(), 15'($urandom()));
      checks++; if (cfg.cfg_ready !== (k % 2 == 1)) begin errors++; $display("FAIL hold_ready[%0d]: got %b want %b", k, cfg.cfg_ready, k % 2 == 1); end
      checks++; if (in_valid !== 1'b0) begin errors++; $display("FAIL hold_in_valid[%0d]: got %b want 0", k, in_valid); end
      if (k % 2 == 1) begin
        checks++; if (x0 !== m_x0) begin errors++; $display("FAIL hold_x0[%0d]: got %0d want %0d", k, x0, m_x0); end
      end
    end
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 32'h0, 32'h0, 15'h0);
      checks++; if (cfg.cfg_ready !== 1'b1 || in_valid !== 1'b0) begin errors++; $display("FAIL hold_idle[%0d]: got %b/%b want 1/0", k, cfg.cfg_ready, in_valid); end
    end
  endtask
  task automatic test_random();
    logic [31:0] f;
    for (int k = 0; k < 800; k++) begin
      f = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom();
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, f, $urandom(), 15'($urandom()));
      checks++; if (cfg.cfg_ready !== !m_load) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", k, cfg.cfg_ready, !m_load); end
      checks++; if (in_valid !== m_iv) begin errors++; $display("FAIL rnd_in_valid[%0d]: got %b want %b", k, in_valid, m_iv); end
      checks++; if (z0 !== m_z0) begin errors++; $display("FAIL rnd_z0[%0d]: got %h want %h", k, z0, m_z0); end
      checks++; if (x0 !== m_x0 || y0 !== 16'h0) begin errors++; $display("FAIL rnd_x0y0[%0d]: got %h/%h want %h/0", k, x0, y0, m_x0); end
      checks++; if (out_valid !== exp_ov()) begin errors++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", k, out_valid, exp_ov()); end
      checks++; if (out_wrap !== exp_ow()) begin errors++; $display("FAIL rnd_out_wrap[%0d]: got %b want %b", k, out_wrap, exp_ow()); end
    end
  endtask
  task automatic test_reset_mid_run();
    cycle(1, 1, 32'h1234_5678, 32'h0, 15'h1234);
    for (int k = 0; k < 25; k++) cycle(1, 0, 32'h0, 32'h0, 15'h0);
    #2;
    assert_reset();
    checks++; if ({x0, z0, in_valid, out_valid, out_wrap} !== 35'h0) begin
      errors++; $display("FAIL midrst_outputs: got %h want 0", {x0, z0, in_valid, out_valid, out_wrap});
    end
    release_reset();
    for (int k = 0; k < 25; k++) begin
      cycle(0, 0, 32'h0, 32'h0, 15'h0);
      checks++; if (out_valid !== 1'b0 || in_valid !== 1'b0) begin errors++; $display("FAIL midrst_quiet[%0d]: got %b/%b want 0/0", k, out_valid, in_valid); end
    end
  endtask
  initial begin
    cfg.cfg_valid = 1'b0;
    cfg.cfg_freq = '0;
    cfg.cfg_phase = '0;
    cfg.cfg_amp = '0;
    test_reset();
    test_quadrants();
    test_enable_gap();
    test_reconfig();
    test_decrement(32'h0001_0000);
    test_decrement(32'h0000_0002);
    test_hold_valid_idle();
    test_random();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
